// File: rtl/bit_serializer_pkg.sv
// Shared constants for the serial bit-stream path (serializer feeding the sequence detector).
// Holds shift-order encodings, the default idle level and stream width constants.
package bit_serializer_pkg;

  localparam bit SHIFT_MSB_FIRST = 1'b1;
  localparam bit SHIFT_LSB_FIRST = 1'b0;

  localparam bit IDLE_BIT_DEFAULT = 1'b0;

  // One bit per clock travels between serializer and detector
  localparam int SER_BIT_W      = 1;
  localparam int DEFAULT_WORD_W = 8;
  localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/serializer_hold_reg.sv
// One-entry holding register with a full flag; lets the serializer accept the
// next word while the current one is still shifting out.
module serializer_hold_reg
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_en,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  // Write and read never coincide: writes are only possible while empty
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
    end else if (write_en) begin
      hold_data <= write_data;
      hold_full <= 1'b1;
    end else if (read_en) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage: words arrive over valid/ready and leave one bit
// per clock with no gap between consecutive words.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WORD_W,
  parameter bit MSB_FIRST = SHIFT_MSB_FIRST,
  parameter bit IDLE_BIT  = IDLE_BIT_DEFAULT,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_start,
  output logic             word_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BC_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [BC_W-1:0]  bit_cnt;
  logic             active;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;

  logic transfer;
  logic at_last;
  logic shifter_free;
  logic load_hold;
  logic load_bypass;

  assign in_ready     = !hold_full && !reset;
  assign transfer     = in_valid && in_ready;
  assign at_last      = active && (bit_cnt == BC_W'(WIDTH - 1));
  assign shifter_free = !active || at_last;
  assign load_hold    = shifter_free && hold_full;
  assign load_bypass  = shifter_free && !hold_full && transfer;

  serializer_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .write_en  (transfer && !shifter_free),
    .write_data(in_data),
    .read_en   (load_hold),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  // A word finishing its last bit can be replaced by the next one on the same
  // edge, which is what keeps ser_valid continuous under back-to-back traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      active     <= 1'b0;
      bit_cnt    <= '0;
      words_sent <= '0;
    end else begin
      if (at_last) begin
        words_sent <= words_sent + CNT_W'(1);
      end
      if (load_hold) begin
        sreg    <= hold_data;
        active  <= 1'b1;
        bit_cnt <= '0;
      end else if (load_bypass) begin
        sreg    <= in_data;
        active  <= 1'b1;
        bit_cnt <= '0;
      end else if (shifter_free) begin
        active <= 1'b0;
      end else begin
        if (MSB_FIRST) begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
        end else begin
          sreg <= {1'b0, sreg[WIDTH-1:1]};
        end
        bit_cnt <= bit_cnt + BC_W'(1);
      end
    end
  end

  assign ser_bit    = active ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;
  assign ser_valid  = active;
  assign word_start = active && (bit_cnt == '0);
  assign word_last  = at_last;
  assign busy       = active || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances (MSB-first, LSB-first,
// 4-bit counter) share one stimulus stream.
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;

  logic        in_ready, ser_bit, ser_valid, word_start, word_last, busy;
  logic [15:0] words_sent;
  logic        l_in_ready, l_ser_bit, l_ser_valid, l_word_start, l_word_last, l_busy;
  logic [15:0] l_words_sent;
  logic        w_in_ready, w_ser_bit, w_ser_valid, w_word_start, w_word_last, w_busy;
  logic [3:0]  w_words_sent;

  int n_tests;
  int n_fail;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .word_start(word_start), .word_last(word_last), .busy(busy),
    .words_sent(words_sent)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(16)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .ser_bit(l_ser_bit), .ser_valid(l_ser_valid),
    .word_start(l_word_start), .word_last(l_word_last), .busy(l_busy),
    .words_sent(l_words_sent)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(w_in_ready), .ser_bit(w_ser_bit), .ser_valid(w_ser_valid),
    .word_start(w_word_start), .word_last(w_word_last), .busy(w_busy),
    .words_sent(w_words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    n_tests++;
    if ({ser_valid, ser_bit, word_start, word_last, busy} !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000",
               {ser_valid, ser_bit, word_start, word_last, busy});
    end
    n_tests++;
    if (words_sent !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_count: got %0d expected 0", words_sent);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp;
    exp = 8'hB0;
    do_reset();
    in_data  = exp;
    in_valid = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if ({ser_valid, ser_bit, word_start, word_last} !==
          {1'b1, exp[7-k], (k == 0), (k == 7)}) begin
        n_fail++;
        $display("[TB] FAIL single_bit%0d: got v/b/s/l=%b expected %b", k,
                 {ser_valid, ser_bit, word_start, word_last},
                 {1'b1, exp[7-k], (k == 0), (k == 7)});
      end
      n_tests++;
      if (l_ser_bit !== exp[k]) begin
        n_fail++;
        $display("[TB] FAIL lsb_b0_bit%0d: got %b expected %b", k, l_ser_bit, exp[k]);
      end
      tick();
    end
    n_tests++;
    if ({ser_valid, ser_bit, busy} !== 3'b000 || words_sent !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL single_done: got v/b/busy=%b cnt=%0d expected 000 cnt=1",
               {ser_valid, ser_bit, busy}, words_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3];
    int          exp_edge [3];
    logic [23:0] stream;
    int          idx;
    logic        exp_ready;
    words    = '{8'hB0, 8'hFF, 8'h0D};
    exp_edge = '{0, 1, 9};
    stream   = 24'hB0FF0D;
    idx      = 0;
    do_reset();
    for (int cyc = 0; cyc <= 24; cyc++) begin
      in_valid = (idx < 3);
      if (idx < 3) in_data = words[idx];
      if (in_valid && in_ready) begin
        n_tests++;
        if (cyc != exp_edge[idx]) begin
          n_fail++;
          $display("[TB] FAIL b2b_accept%0d: got edge %0d expected %0d",
                   idx, cyc, exp_edge[idx]);
        end
        idx++;
      end
      tick();
      if (cyc <= 23) begin
        n_tests++;
        if (ser_valid !== 1'b1 || ser_bit !== stream[23-cyc]) begin
          n_fail++;
          $display("[TB] FAIL b2b_bit%0d: got v=%b b=%b expected v=1 b=%b",
                   cyc, ser_valid, ser_bit, stream[23-cyc]);
        end
      end else begin
        n_tests++;
        if (ser_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL b2b_end_valid: got %b expected 0", ser_valid);
        end
      end
      exp_ready = !((cyc >= 1 && cyc <= 7) || (cyc >= 9 && cyc <= 15));
      n_tests++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready%0d: got %b expected %b", cyc, in_ready, exp_ready);
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (words_sent !== 16'd3 || idx != 3) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got cnt=%0d accepted=%0d expected 3/3",
               words_sent, idx);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_seq;
    exp_seq = 8'b0000_1101;
    do_reset();
    in_data  = 8'h0D;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (l_ser_valid !== 1'b1 || l_ser_bit !== exp_seq[k]) begin
        n_fail++;
        $display("[TB] FAIL lsb_bit%0d: got v=%b b=%b expected v=1 b=%b",
                 k, l_ser_valid, l_ser_bit, exp_seq[k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    in_data  = 8'hB0;
    in_valid = 1'b1;
    tick();
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_hold_full: got busy=%b ready=%b expected 1/0", busy, in_ready);
    end
    tick();
    tick();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_ready_in_reset: got %b expected 0", in_ready);
    end
    tick();
    n_tests++;
    if ({ser_valid, ser_bit, busy} !== 3'b000 || words_sent !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_state: got v/b/busy=%b cnt=%0d expected 000 cnt=0",
               {ser_valid, ser_bit, busy}, words_sent);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_ready_after: got %b expected 1", in_ready);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || ser_valid !== 1'b0 || words_sent !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_discard: got busy=%b v=%b cnt=%0d expected 0/0/0",
               busy, ser_valid, words_sent);
    end
  endtask

  task automatic test_idle_gap();
    do_reset();
    in_data  = 8'hB0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (ser_valid !== 1'b0 || ser_bit !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL gap_idle%0d: got v=%b b=%b expected 0/0", k, ser_valid, ser_bit);
      end
    end
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({ser_valid, word_start, ser_bit} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL gap_restart: got v/s/b=%b expected 111",
               {ser_valid, word_start, ser_bit});
    end
  endtask

  task automatic test_counter_wrap();
    int accepted;
    int cyc;
    do_reset();
    accepted = 0;
    cyc      = 0;
    in_data  = 8'hA5;
    while ((accepted < 17 || busy) && cyc < 400) begin
      in_valid = (accepted < 17);
      if (in_valid && in_ready) accepted++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (cyc >= 400) begin
      n_fail++;
      $display("[TB] FAIL wrap_timeout: got %0d accepted, busy=%b expected 17 done",
               accepted, busy);
    end
    n_tests++;
    if (w_words_sent !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL wrap_count4: got %0d expected 1", w_words_sent);
    end
    n_tests++;
    if (words_sent !== 16'd17) begin
      n_fail++;
      $display("[TB] FAIL wrap_count16: got %0d expected 17", words_sent);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_idle_gap();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
